// File: rtl/muxn_rr.sv
// muxn_rr: registered N-channel, W-bit multiplexer with valid/ready handshaking
// on every input channel and on the output. Supports fixed select (mode=0) and
// round-robin arbitration among valid channels (mode=1).
module muxn_rr #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    r_outData;
    logic [SEL_W-1:0]    r_outChan;
    logic                r_outValid;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_loadEn;
    logic                w_grantValid;
    logic [SEL_W-1:0]    w_grant;
    logic [WIDTH-1:0]    w_grantData;
    logic [CHANNELS-1:0] w_inReady;
    logic                w_xfer;

    // The output register can take new data when it is empty or being drained this cycle.
    assign w_loadEn = !r_outValid || out_ready;

    // Pick the granted channel: fixed index in mode 0, first valid after the pointer in mode 1.
    always_comb begin
        int idx;
        w_grantValid = 1'b0;
        w_grant      = '0;
        idx          = 0;
        if (!mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    w_grantValid = 1'b1;
                    w_grant      = SEL_W'(i);
                end
            end
        end else begin
            for (int off = 1; off <= CHANNELS; off++) begin
                idx = (int'(r_ptr) + off) % CHANNELS;
                if (!w_grantValid && in_valid[idx]) begin
                    w_grantValid = 1'b1;
                    w_grant      = SEL_W'(idx);
                end
            end
        end
    end

    // Route the granted channel's data toward the output register.
    always_comb begin
        w_grantData = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_grantData = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready goes only to the granted channel, and never while reset is held.
    always_comb begin
        w_inReady = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_inReady[i] = !reset && w_loadEn && w_grantValid && (w_grant == SEL_W'(i));
        end
    end

    // A grant only exists for a valid channel, so a grant while loadable is a transfer.
    assign w_xfer = w_loadEn && w_grantValid;

    // Output register and round-robin pointer; a load and a drain in one cycle are a single transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outChan  <= '0;
            r_ptr      <= SEL_W'(CHANNELS - 1);
        end else if (w_xfer) begin
            r_outValid <= 1'b1;
            r_outData  <= w_grantData;
            r_outChan  <= w_grant;
            r_ptr      <= w_grant;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign in_ready  = w_inReady;
    assign out_data  = r_outData;
    assign out_chan  = r_outChan;
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_muxn_rr.sv
// tb_muxn_rr: directed-vector bench for muxn_rr (4-channel instance plus a
// 3-channel instance for the out-of-range select case).
module tb_muxn_rr;

    logic        clk;
    logic        reset;

    // Main instance: WIDTH=8, CHANNELS=4
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] inData;
    logic [3:0]  inValid;
    logic [3:0]  inReady;
    logic [7:0]  outData;
    logic [1:0]  outChan;
    logic        outValid;
    logic        outReady;

    // Secondary instance: WIDTH=8, CHANNELS=3
    logic        modeB;
    logic [1:0]  selB;
    logic [23:0] inDataB;
    logic [2:0]  inValidB;
    logic [2:0]  inReadyB;
    logic [7:0]  outDataB;
    logic [1:0]  outChanB;
    logic        outValidB;
    logic        outReadyB;

    int checks;
    int failures;

    muxn_rr #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out_data  (outData),
        .out_chan  (outChan),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    muxn_rr #(.WIDTH(8), .CHANNELS(3)) dutB (
        .clk       (clk),
        .reset     (reset),
        .mode      (modeB),
        .sel       (selB),
        .in_data   (inDataB),
        .in_valid  (inValidB),
        .in_ready  (inReadyB),
        .out_data  (outDataB),
        .out_chan  (outChanB),
        .out_valid (outValidB),
        .out_ready (outReadyB)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the control inputs of the main instance.
    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
        mode     = m;
        sel      = s;
        inValid  = v;
        outReady = r;
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle reset pulse; afterwards the pointer sits at the last channel.
    task automatic pulseReset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] rrSeq [6];
        logic [1:0] sparseSeq [4];
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(1'b0, 2'd0, 4'b0000, 1'b0);
        inData    = 32'h44332211;
        modeB     = 1'b0;
        selB      = 2'd0;
        inDataB   = 24'hCCBBAA;
        inValidB  = 3'b000;
        outReadyB = 1'b0;

        // Reset state, and ready held low while reset is asserted.
        repeat (2) cycle();
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_out_data", 32'(outData), 32'h00);
        checkOutput("rst_out_chan", 32'(outChan), 32'd0);
        inValid  = 4'b1111;
        outReady = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(inReady), 32'b0000);

        // Idle after reset: nothing valid, nothing moves.
        reset = 1'b0;
        applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cycle();
            checkOutput("idle_out_valid", 32'(outValid), 32'd0);
            checkOutput("idle_out_data", 32'(outData), 32'h00);
            checkOutput("idle_in_ready", 32'(inReady), 32'b0000);
        end

        // Fixed select of channel 2 with every channel valid.
        applyStimulus(1'b0, 2'd2, 4'b1111, 1'b1);
        #1;
        checkOutput("fixed_in_ready_first", 32'(inReady), 32'b0100);
        for (int k = 0; k < 4; k++) begin
            cycle();
            checkOutput("fixed_out_valid", 32'(outValid), 32'd1);
            checkOutput("fixed_out_data", 32'(outData), 32'h33);
            checkOutput("fixed_out_chan", 32'(outChan), 32'd2);
            checkOutput("fixed_in_ready", 32'(inReady), 32'b0100);
        end

        // Round-robin with every channel valid: 0,1,2,3,0,1 back to back.
        rrSeq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        pulseReset();
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cycle();
            checkOutput("rr_out_valid", 32'(outValid), 32'd1);
            checkOutput("rr_out_chan", 32'(outChan), 32'(rrSeq[k]));
            checkOutput("rr_out_data", 32'(outData), 32'h11 * (32'(rrSeq[k]) + 1));
        end

        // Sparse round-robin: channels 1 and 3 alternate, then channel 1 alone.
        sparseSeq = '{2'd1, 2'd3, 2'd1, 2'd3};
        pulseReset();
        applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1);
        #1;
        checkOutput("sparse_in_ready_first", 32'(inReady), 32'b0010);
        for (int k = 0; k < 4; k++) begin
            cycle();
            checkOutput("sparse_out_chan", 32'(outChan), 32'(sparseSeq[k]));
        end
        inValid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checkOutput("sparse_single_chan", 32'(outChan), 32'd1);
            checkOutput("sparse_single_data", 32'(outData), 32'h22);
        end

        // Back-pressure: hold 0x22 while select and data wiggle, then load with no bubble.
        pulseReset();
        applyStimulus(1'b0, 2'd1, 4'b1111, 1'b0);
        cycle();
        checkOutput("bp_load_data", 32'(outData), 32'h22);
        checkOutput("bp_load_chan", 32'(outChan), 32'd1);
        checkOutput("bp_load_valid", 32'(outValid), 32'd1);
        inData[31:24] = 8'h99;
        for (int k = 0; k < 5; k++) begin
            sel  = 2'(k + 2);
            mode = k[0];
            #1;
            checkOutput("bp_in_ready", 32'(inReady), 32'b0000);
            cycle();
            checkOutput("bp_hold_data", 32'(outData), 32'h22);
            checkOutput("bp_hold_chan", 32'(outChan), 32'd1);
            checkOutput("bp_hold_valid", 32'(outValid), 32'd1);
        end
        applyStimulus(1'b0, 2'd3, 4'b1111, 1'b1);
        #1;
        checkOutput("bp_release_in_ready", 32'(inReady), 32'b1000);
        cycle();
        checkOutput("bp_release_valid", 32'(outValid), 32'd1);
        checkOutput("bp_release_data", 32'(outData), 32'h99);
        checkOutput("bp_release_chan", 32'(outChan), 32'd3);
        inData[31:24] = 8'h44;

        // Reset in the middle of round-robin traffic restarts arbitration at channel 0.
        pulseReset();
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        repeat (3) cycle();
        checkOutput("midrst_pre_chan", 32'(outChan), 32'd2);
        reset = 1'b1;
        #1;
        checkOutput("midrst_in_ready_held", 32'(inReady), 32'b0000);
        cycle();
        checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
        checkOutput("midrst_out_chan", 32'(outChan), 32'd0);
        checkOutput("midrst_out_data", 32'(outData), 32'h00);
        reset = 1'b0;
        #1;
        checkOutput("midrst_in_ready_after", 32'(inReady), 32'b0001);
        cycle();
        checkOutput("midrst_next_chan", 32'(outChan), 32'd0);
        checkOutput("midrst_next_valid", 32'(outValid), 32'd1);
        checkOutput("midrst_next_data", 32'(outData), 32'h11);

        // Three-channel instance: select index 3 does not exist, index 2 does.
        modeB     = 1'b0;
        selB      = 2'd3;
        inValidB  = 3'b111;
        outReadyB = 1'b1;
        #1;
        checkOutput("c3_sel3_in_ready", 32'(inReadyB), 32'b000);
        cycle();
        checkOutput("c3_sel3_out_valid", 32'(outValidB), 32'd0);
        selB = 2'd2;
        #1;
        checkOutput("c3_sel2_in_ready", 32'(inReadyB), 32'b100);
        cycle();
        checkOutput("c3_sel2_out_chan", 32'(outChanB), 32'd2);
        checkOutput("c3_sel2_out_data", 32'(outDataB), 32'hCC);
        checkOutput("c3_sel2_out_valid", 32'(outValidB), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
